uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port sclk  input  1  system clock, all state on rising edge; the block has one clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port rs232_rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte received.
REQ-007 SHALL have port rx_valid  output  1  single-cycle pulse: rx_data updated this cycle.
REQ-008 SHALL have port rx_frame_err  output  1  single-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-010 SHALL pass rs232_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-011 SHALL derive BAUD_CNT = CLK_FREQ/BAUD (integer, 434 at defaults) and HALF = BAUD_CNT/2 (217).
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a bit-period counter counting 0..BAUD_CNT-1 and a 3-bit bit index.
REQ-013 IDLE: on a synchronized 1->0 transition SHALL enter START with the counter at 0.
REQ-014 Each bit SHALL be decided by a 2-of-3 majority of the synchronized samples at counter values HALF-1, HALF and HALF+1, with the decision taken at HALF+1.
REQ-015 START: if the majority is 1 (glitch), SHALL return to IDLE with no output pulse; otherwise SHALL continue to count to BAUD_CNT-1 and then enter DATA with bit index 0.
REQ-016 DATA: SHALL shift each decided bit into a shift register LSB first; after the bit-7 period ends SHALL enter STOP.
REQ-017 STOP: at the HALF+1 decision SHALL return to IDLE immediately, without waiting for the end of the stop bit, so that back-to-back frames are accepted.
REQ-018 If the stop bit is decided 1, SHALL load rx_data from the shift register and pulse rx_valid in the next cycle.
REQ-019 If the stop bit is decided 0, SHALL pulse rx_frame_err in the next cycle and leave rx_data unchanged; a line held low SHALL not retrigger until a 0->1->0 sequence is seen.
REQ-020 rx_valid and rx_frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 Counter width SHALL be clog2(BAUD_CNT); the counter SHALL never wrap past BAUD_CNT-1.

Reset
REQ-022 While reset = 0: state = IDLE, counter = 0, bit index = 0, shift register = 0x00, rx_data = 0x00, rx_valid = 0, rx_frame_err = 0, rx_busy = 0, synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-024 Package uart_pkg SHALL hold the CLK_FREQ/BAUD defaults, the BAUD_CNT/HALF derivation and the state encodings, so that they are shared with the transmit side.
REQ-025 The synchronizer and edge detector SHALL be a sub-module named rx_sync; everything else SHALL be in uart_byte_rx.

Verification
REQ-026 Scenario: 50 MHz clock, 8680 ns bits, send 0xA7 -> one rx_valid pulse with rx_data = 0xA7 between 9.4 and 9.6 bit times after the start edge; rx_frame_err stays 0.
REQ-027 Scenario: 0xA7 then 0xC9 back-to-back with no idle gap, repeated 4 times -> 8 rx_valid pulses alternating A7/C9; no errors.
REQ-028 Scenario: low pulse of 2000 ns on an idle line -> no pulse; rx_busy returns to 0 within 4.5 µs.
REQ-029 Scenario: 0x55 with the stop bit driven 0 -> rx_frame_err pulses once, rx_data keeps its prior value, rx_valid stays 0.
REQ-030 Scenario: reset = 0 during bit 3 of 0xC9, released 1 µs later, then send 0x3C -> only 0x3C is reported, and all outputs are at reset values while reset = 0.
REQ-031 Scenario: bit period of 8900 ns (+2.5%) and of 8460 ns (-2.5%), each sending 0xA7 -> rx_data = 0xA7 and rx_valid pulses in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, bit-period derivation and
// receiver state encodings, common to the receive and transmit sides.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115200;

  // Whole system clocks per serial bit (434 at the defaults).
  function automatic int unsigned baud_cnt(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
// All flops reset to 1 so that a line idling high never looks like an edge.
module rx_sync (
  input  logic sclk,
  input  logic reset,
  input  logic rs232_rx,
  output logic rx_s,
  output logic fall
);

  logic sync_1;
  logic sync_d;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync_1 <= rs232_rx;
      rx_s   <= sync_1;
      sync_d <= rx_s;
    end
  end

  // A fall needs a preceding 1, so a line stuck low cannot retrigger.
  assign fall = sync_d & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-of-3 majority voting around each bit centre,
// early return to IDLE at the stop-bit decision for back-to-back frames.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy,
  output rx_state_e  dbg_state
);

  localparam int unsigned BAUD_CNT = baud_cnt(CLK_FREQ, BAUD);
  localparam int unsigned HALF     = BAUD_CNT / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);

  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg;
  logic             smp_a, smp_b;
  logic             rx_s, fall;
  logic             maj, decide, cnt_end;
  logic             shift_en, load_data, frame_err;

  rx_sync u_sync (
    .sclk     (sclk),
    .reset    (reset),
    .rs232_rx (rs232_rx),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  // Third vote is the live sample, taken on the decision cycle itself.
  assign maj     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign decide  = (cnt == SMP_C);
  assign cnt_end = (cnt == CNT_LAST);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_end ? '0 : cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    load_data   = 1'b0;
    frame_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (fall) state_nxt = ST_START;
      end
      ST_START: begin
        if (decide && maj) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        shift_en = decide;
        if (cnt_end) begin
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (decide) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          load_data = maj;
          frame_err = ~maj;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      smp_a        <= 1'b1;
      smp_b        <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      if (cnt == SMP_A) smp_a <= rx_s;
      if (cnt == SMP_B) smp_b <= rx_s;
      if (shift_en)     shreg <= {maj, shreg[7:1]};
      if (load_data)    rx_data <= shreg;
      rx_valid     <= load_data;
      rx_frame_err <= frame_err;
    end
  end

  assign rx_busy   = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: frame table, back-to-back, glitch and mid-frame
// reset sequences, with a byte scoreboard fed by the serial driver.
module tb_uart_byte_rx;
  import uart_pkg::*;

  logic       sclk = 1'b0;
  logic       reset;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  rx_state_e  dbg_state;

  // ---------------- clock / reset ----------------
  always #10 sclk = ~sclk;

  uart_byte_rx dut (
    .sclk         (sclk),
    .reset        (reset),
    .rs232_rx     (rs232_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .dbg_state    (dbg_state)
  );

  int         chk_cnt   = 0;
  int         fail_cnt  = 0;
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  longint     last_valid_t = 0;
  longint     start_t      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    int         bit_ns;
    bit         stop_bit;
    int         exp_valid;
    int         exp_err;
    bit         chk_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input logic [7:0] d, input int bit_ns, input bit stop_bit);
    if (stop_bit) exp_q.push_back(d);
    start_t  = $time;
    rs232_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      #(bit_ns);
    end
    rs232_rx = stop_bit;
    #(bit_ns);
    rs232_rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},      rx_data,      8'h00);
    check({tag, "_rx_valid"},     rx_valid,     1'b0);
    check({tag, "_rx_frame_err"}, rx_frame_err, 1'b0);
    check({tag, "_rx_busy"},      rx_busy,      1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge sclk) begin
    if (reset === 1'b1) begin
      if (rx_valid === 1'b1) begin
        valid_cnt++;
        last_valid_t = $time;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_valid: got rx_data 0x%0h, expected no pulse", rx_data);
        end else begin
          check("sb_rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (rx_frame_err === 1'b1) err_cnt++;
      if (rx_valid === 1'b1 && rx_frame_err === 1'b1) begin
        chk_cnt++;
        fail_cnt++;
        $display("FAIL valid_err_overlap: got both high, expected at most one");
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0, e0;
    longint lat, t0;

    vecs[0] = '{8'hA7, 8680, 1'b1, 1, 0, 1'b1};
    vecs[1] = '{8'hA7, 8900, 1'b1, 1, 0, 1'b0};
    vecs[2] = '{8'hA7, 8460, 1'b1, 1, 0, 1'b0};
    vecs[3] = '{8'h55, 8680, 1'b0, 0, 1, 1'b0};
    vecs[4] = '{8'h00, 8680, 1'b1, 1, 0, 1'b0};

    rs232_rx = 1'b1;
    reset    = 1'b1;
    #5 reset = 1'b0;
    repeat (5) @(negedge sclk);
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (20) @(negedge sclk);

    // Table-driven frames: nominal, +/-2.5% bit rate, bad stop bit, all-zero data.
    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].bit_ns, vecs[i].stop_bit);
      #(vecs[i].bit_ns);
      if (vecs[i].exp_valid != 0) model_data = vecs[i].data;
      check($sformatf("v%0d_valid_cnt", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_err_cnt", i),   err_cnt - e0,   vecs[i].exp_err);
      check($sformatf("v%0d_rx_data", i),   rx_data,        model_data);
      check($sformatf("v%0d_rx_busy", i),   rx_busy,        1'b0);
      if (vecs[i].chk_lat) begin
        lat = last_valid_t - start_t;
        chk_cnt++;
        if (lat * 10 < 94 * vecs[i].bit_ns || lat * 10 > 96 * vecs[i].bit_ns) begin
          fail_cnt++;
          $display("FAIL v%0d_latency: got %0d, expected %0d..%0d", i, lat,
                   94 * vecs[i].bit_ns / 10, 96 * vecs[i].bit_ns / 10);
        end
      end
    end

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int r = 0; r < 4; r++) begin
      send_frame(8'hA7, 8680, 1'b1);
      send_frame(8'hC9, 8680, 1'b1);
    end
    #(8680);
    model_data = 8'hC9;
    check("b2b_valid_cnt", valid_cnt - v0, 8);
    check("b2b_err_cnt",   err_cnt - e0,   0);
    check("b2b_rx_data",   rx_data,        model_data);
    check("b2b_queue_empty", exp_q.size(), 0);

    // 2 us glitch on an idle line.
    v0 = valid_cnt;
    e0 = err_cnt;
    t0 = $time;
    rs232_rx = 1'b0;
    #2000 rs232_rx = 1'b1;
    #(1000 - ($time - t0 - 2000));
    #(1000 - ($time - t0 - 2000));
    check("glitch_busy_early", rx_busy, 1'b1);
    #(4500 - ($time - t0));
    check("glitch_busy_done", rx_busy, 1'b0);
    #(20000);
    check("glitch_valid_cnt", valid_cnt - v0, 0);
    check("glitch_err_cnt",   err_cnt - e0,   0);

    // Reset asserted during bit 3 of 0xC9; the sender abandons that frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    rs232_rx = 1'b0;
    #(8680);
    for (int i = 0; i < 3; i++) begin
      rs232_rx = (8'hC9 >> i) & 1;
      #(8680);
    end
    rs232_rx = 1'b1;
    #(3000);
    check("pre_reset_busy", rx_busy, 1'b1);
    reset = 1'b0;
    #(500);
    check_reset_outputs("mid");
    #(500);
    check_reset_outputs("mid_late");
    reset = 1'b1;
    model_data = 8'h00;
    #(2 * 8680);
    send_frame(8'h3C, 8680, 1'b1);
    #(8680);
    model_data = 8'h3C;
    check("rst_valid_cnt", valid_cnt - v0, 1);
    check("rst_err_cnt",   err_cnt - e0,   0);
    check("rst_rx_data",   rx_data,        model_data);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
